// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the 16-point FFT output reorder path.
package fft_pkg;

  localparam int NBITS = 16;
  localparam int LOG2N = 4;
  localparam int N     = 1 << LOG2N;

  typedef logic [LOG2N-1:0]   idx_t;
  typedef logic [2*NBITS-1:0] word_t;

  localparam idx_t LAST_IDX = idx_t'(N - 1);

  typedef enum logic {IDLE, DRAIN} rd_state_e;

  function automatic idx_t bitrev(input idx_t a);
    idx_t r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Stream handshake bundle around the reorder buffer: bit-reversed input side
// from the FFT core and natural-order output side with end-of-frame marker.
interface fft_out_reorder_if;
  import fft_pkg::*;

  logic             in_push;
  logic [NBITS-1:0] in_real;
  logic [NBITS-1:0] in_imag;
  logic             in_stall;
  logic             out_push_F;
  logic [NBITS-1:0] out_real_F;
  logic [NBITS-1:0] out_imag_F;
  logic             out_last_F;
  logic             out_stall;

  modport master (
    output in_push, in_real, in_imag, out_stall,
    input  in_stall, out_push_F, out_real_F, out_imag_F, out_last_F
  );

  modport slave (
    input  in_push, in_real, in_imag, out_stall,
    output in_stall, out_push_F, out_real_F, out_imag_F, out_last_F
  );

endinterface

// File: rtl/fft_reorder_bank.sv
// Two-bank ping-pong sample store: one synchronous write port, one
// asynchronous read port.
module fft_reorder_bank
  import fft_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  logic  wr_bank,
  input  idx_t  wr_addr,
  input  word_t wr_data,
  input  logic  rd_bank,
  input  idx_t  rd_addr,
  output word_t rd_data
);

  word_t mem [2][N];

  // NOTE: no reset on the array; the read side only reaches a bank after all
  // N words of it have been written, so stale contents are never observed.
  // NOTE: non-blocking assignment keeps the write ordered after every read of
  // the same edge.
  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/fft_out_reorder.sv
// Reorders bit-reversed FFT results into natural order through a ping-pong
// buffer; write and read counters, full flags and the drain FSM live here.
module fft_out_reorder
  import fft_pkg::*;
(
  input logic               clk,
  input logic               reset,
  fft_out_reorder_if.slave  bus
);

  rd_state_e        state, state_next;
  logic [1:0]       full, full_set, full_clr;
  logic             wr_bank, rd_bank;
  idx_t             wr_cnt, rd_cnt;
  idx_t             wr_addr;
  logic             accept, load;
  word_t            rd_data;
  logic             out_push_q, out_last_q;
  logic [NBITS-1:0] out_real_q, out_imag_q;

  // Stall depends on registered flags only, so there is no in_push -> in_stall path.
  assign bus.in_stall = full[wr_bank];
  assign accept       = bus.in_push && !full[wr_bank];
  assign wr_addr      = bitrev(wr_cnt);

  fft_reorder_bank u_bank (
    .clk     (clk),
    .we      (accept),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data ({bus.in_real, bus.in_imag}),
    .rd_bank (rd_bank),
    .rd_addr (rd_cnt),
    .rd_data (rd_data)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    full_set   = '0;
    full_clr   = '0;
    if (accept && wr_cnt == LAST_IDX) full_set[wr_bank] = 1'b1;
    case (state)
      IDLE: if (full[rd_bank]) state_next = DRAIN;
      DRAIN: begin
        load = !out_push_q || !bus.out_stall;
        if (load && rd_cnt == LAST_IDX) begin
          full_clr[rd_bank] = 1'b1;
          state_next        = full[~rd_bank] ? DRAIN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      full       <= '0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      out_push_q <= 1'b0;
      out_last_q <= 1'b0;
      out_real_q <= '0;
      out_imag_q <= '0;
    end else begin
      state <= state_next;
      // Set and clear always target different banks, so both can land together.
      full  <= (full | full_set) & ~full_clr;
      if (accept) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == LAST_IDX) wr_bank <= ~wr_bank;
      end
      if (load) begin
        {out_real_q, out_imag_q} <= rd_data;
        out_push_q               <= 1'b1;
        out_last_q               <= (rd_cnt == LAST_IDX);
        rd_cnt                   <= rd_cnt + 1'b1;
        if (rd_cnt == LAST_IDX) rd_bank <= ~rd_bank;
      end else if (!bus.out_stall) begin
        out_push_q <= 1'b0;
        out_last_q <= 1'b0;
      end
    end
  end

  assign bus.out_push_F = out_push_q;
  assign bus.out_last_F = out_last_q;
  assign bus.out_real_F = out_real_q;
  assign bus.out_imag_F = out_imag_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Randomized bench for fft_out_reorder: a frame-level model maps each accepted
// input frame to its natural-order output and the observed stream is compared to it.
module tb_fft_out_reorder;
  import fft_pkg::*;

  typedef struct {
    logic [NBITS-1:0] re;
    logic [NBITS-1:0] im;
    logic             last;
    int               cyc;
  } smp_t;

  logic clk = 1'b0;
  logic reset;
  fft_out_reorder_if bus();

  fft_out_reorder dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_acc_edge = 0;
  smp_t acc_q[$];
  smp_t exp_q[$];
  smp_t got_q[$];

  function automatic int ref_bitrev(input int x);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) r = r * 2 + ((x >> b) % 2);
    return r;
  endfunction

  function automatic logic [NBITS-1:0] rnd16();
    logic [NBITS-1:0] v = NBITS'($urandom);
    return (v == 16'h7FFF) ? '0 : v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model: an accepted frame in[k] comes out as X[n] = in[bitrev(n)], last on n = N-1.
  always @(negedge clk) begin : monitor
    smp_t s;
    if (reset) begin
      acc_q.delete();
      exp_q.delete();
      got_q.delete();
    end else begin
      if (bus.in_push && !bus.in_stall) begin
        s.re = bus.in_real; s.im = bus.in_imag; s.last = 1'b0; s.cyc = cyc + 1;
        acc_q.push_back(s);
        last_acc_edge = cyc + 1;
        if (acc_q.size() == N) begin
          for (int n = 0; n < N; n++) begin
            s      = acc_q[ref_bitrev(n)];
            s.last = (n == N - 1);
            exp_q.push_back(s);
          end
          acc_q.delete();
        end
      end
      if (bus.out_push_F && !bus.out_stall) begin
        s.re = bus.out_real_F; s.im = bus.out_imag_F; s.last = bus.out_last_F; s.cyc = cyc;
        got_q.push_back(s);
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic push_sample(input logic [NBITS-1:0] re, input logic [NBITS-1:0] im,
                             inout int stalls);
    int tries = 0;
    bus.in_push = 1'b1;
    bus.in_real = re;
    bus.in_imag = im;
    forever begin
      @(negedge clk);
      if (!bus.in_stall) break;
      stalls++;
      tries++;
      if (tries > 2000) begin
        total++; bad++;
        $display("FAIL push_timeout in_stall=%0b required=0", bus.in_stall);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_outputs(input int n, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (got_q.size() >= n) return;
      @(posedge clk); #1;
    end
    total++; bad++;
    $display("FAIL output_timeout got=%0d required=%0d", got_q.size(), n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_push = 1'b0;
    bus.out_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (bus.out_push_F !== 1'b0) begin bad++; $display("FAIL rst_push got=%b want=0", bus.out_push_F); end
    total++; if (bus.out_real_F !== '0)   begin bad++; $display("FAIL rst_real got=%h want=0", bus.out_real_F); end
    total++; if (bus.out_imag_F !== '0)   begin bad++; $display("FAIL rst_imag got=%h want=0", bus.out_imag_F); end
    total++; if (bus.out_last_F !== 1'b0) begin bad++; $display("FAIL rst_last got=%b want=0", bus.out_last_F); end
    total++; if (bus.in_stall !== 1'b0)   begin bad++; $display("FAIL rst_in_stall got=%b want=0", bus.in_stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    int st = 0;
    int e_edge;
    logic [NBITS-1:0] want_re, want_im;
    do_reset();
    for (int k = 0; k < N; k++) push_sample(NBITS'(k), NBITS'(-k), st);
    bus.in_push = 1'b0;
    e_edge = last_acc_edge;
    wait_outputs(N, 100);
    total++;
    if (got_q.size() != N) begin bad++; $display("FAIL single_count got=%0d want=%0d", got_q.size(), N); end
    for (int n = 0; n < got_q.size() && n < N; n++) begin
      want_re = NBITS'(ref_bitrev(n));
      want_im = NBITS'(-ref_bitrev(n));
      total++;
      if ({got_q[n].re, got_q[n].im, got_q[n].last} !== {want_re, want_im, n == N - 1}) begin
        bad++;
        $display("FAIL single_x%0d got=%h/%h/%b want=%h/%h/%b", n, got_q[n].re, got_q[n].im,
                 got_q[n].last, want_re, want_im, n == N - 1);
      end
    end
    if (got_q.size() > 0) begin
      total++;
      if (got_q[0].cyc != e_edge + 2) begin
        bad++; $display("FAIL single_latency got_edge=%0d want_edge=%0d", got_q[0].cyc, e_edge + 2);
      end
    end
    @(negedge clk);
    total++;
    if ({bus.out_push_F, bus.out_last_F} !== 2'b00) begin
      bad++; $display("FAIL single_idle got=%b want=00", {bus.out_push_F, bus.out_last_F});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int st_first = 0;
    int st_rest  = 0;
    int gaps     = 0;
    do_reset();
    for (int k = 0; k < N; k++) push_sample(rnd16(), rnd16(), st_first);
    for (int k = 0; k < 3 * N; k++) push_sample(rnd16(), rnd16(), st_rest);
    bus.in_push = 1'b0;
    wait_outputs(4 * N, 400);
    // Frame 3 wants bank 0 on the very edge that loads frame 1's last word, so
    // exactly one input stall occurs; it then completes on the edge frame 2 drains
    // its last word, so the drain FSM idles for exactly one cycle before frame 3.
    total++;
    if (st_rest != 1) begin bad++; $display("FAIL b2b_in_stall got=%0d want=1", st_rest); end
    for (int i = 1; i < got_q.size(); i++) gaps += got_q[i].cyc - got_q[i-1].cyc - 1;
    total++;
    if (gaps != 1) begin bad++; $display("FAIL b2b_gaps got=%0d want=1", gaps); end
    total++;
    if (got_q.size() != 4 * N || exp_q.size() != 4 * N) begin
      bad++; $display("FAIL b2b_count got=%0d want=%0d", got_q.size(), 4 * N);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if ({got_q[i].re, got_q[i].im, got_q[i].last} !== {exp_q[i].re, exp_q[i].im, exp_q[i].last}) begin
        bad++;
        $display("FAIL b2b_x%0d got=%h/%h/%b want=%h/%h/%b", i, got_q[i].re, got_q[i].im,
                 got_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].last);
      end
    end
  endtask

  task automatic test_backpressure();
    int st = 0;
    logic [2*NBITS+1:0] held, now;
    do_reset();
    fork
      begin
        for (int k = 0; k < 3 * N; k++) push_sample(rnd16(), rnd16(), st);
        bus.in_push = 1'b0;
      end
      begin
        wait_outputs(1, 100);
        bus.out_stall = 1'b1;
        held = {bus.out_push_F, bus.out_real_F, bus.out_imag_F, bus.out_last_F};
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          now = {bus.out_push_F, bus.out_real_F, bus.out_imag_F, bus.out_last_F};
          total++;
          if (now !== held) begin bad++; $display("FAIL bp_hold%0d got=%h want=%h", c, now, held); end
          if (c == 39) begin
            total++;
            if (bus.in_stall !== 1'b1) begin bad++; $display("FAIL bp_in_stall got=%b want=1", bus.in_stall); end
          end
          @(posedge clk); #1;
        end
        bus.out_stall = 1'b0;
      end
    join
    wait_outputs(3 * N, 400);
    total++;
    if (got_q.size() != 3 * N || exp_q.size() != 3 * N) begin
      bad++; $display("FAIL bp_count got=%0d want=%0d", got_q.size(), 3 * N);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if ({got_q[i].re, got_q[i].im, got_q[i].last} !== {exp_q[i].re, exp_q[i].im, exp_q[i].last}) begin
        bad++;
        $display("FAIL bp_x%0d got=%h/%h/%b want=%h/%h/%b", i, got_q[i].re, got_q[i].im,
                 got_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].last);
      end
    end
  endtask

  task automatic test_illegal_push();
    int st = 0;
    int hits = 0;
    do_reset();
    bus.out_stall = 1'b1;
    for (int k = 0; k < 2 * N; k++) push_sample(rnd16(), rnd16(), st);
    @(negedge clk);
    total++;
    if (bus.in_stall !== 1'b1) begin bad++; $display("FAIL ill_in_stall got=%b want=1", bus.in_stall); end
    @(posedge clk); #1;
    bus.in_push = 1'b1;
    bus.in_real = 16'h7FFF;
    bus.in_imag = 16'h7FFF;
    repeat (5) @(posedge clk);
    #1 bus.in_push = 1'b0;
    bus.out_stall = 1'b0;
    // A following frame only reorders correctly if the write counter never moved.
    for (int k = 0; k < N; k++) push_sample(rnd16(), rnd16(), st);
    bus.in_push = 1'b0;
    wait_outputs(3 * N, 400);
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i].re == 16'h7FFF || got_q[i].im == 16'h7FFF) hits++;
    total++;
    if (hits != 0) begin bad++; $display("FAIL ill_leak got=%0d want=0", hits); end
    total++;
    if (got_q.size() != 3 * N || exp_q.size() != 3 * N) begin
      bad++; $display("FAIL ill_count got=%0d want=%0d", got_q.size(), 3 * N);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if ({got_q[i].re, got_q[i].im, got_q[i].last} !== {exp_q[i].re, exp_q[i].im, exp_q[i].last}) begin
        bad++;
        $display("FAIL ill_x%0d got=%h/%h/%b want=%h/%h/%b", i, got_q[i].re, got_q[i].im,
                 got_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].last);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int st = 0;
    do_reset();
    bus.out_stall = 1'b1;
    for (int k = 0; k < 2 * N; k++) push_sample(rnd16(), rnd16(), st);
    @(negedge clk);
    total++;
    if (bus.in_stall !== 1'b1) begin bad++; $display("FAIL mid_pre_stall got=%b want=1", bus.in_stall); end
    @(posedge clk); #1;
    bus.out_stall = 1'b0;
    wait_outputs(8, 100);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.out_push_F, bus.out_real_F, bus.out_imag_F, bus.out_last_F, bus.in_stall} !== '0) begin
      bad++;
      $display("FAIL mid_reset got=%b/%h/%h/%b/%b want=0", bus.out_push_F, bus.out_real_F,
               bus.out_imag_F, bus.out_last_F, bus.in_stall);
    end
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) push_sample(rnd16(), rnd16(), st);
    bus.in_push = 1'b0;
    wait_outputs(N, 100);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (got_q.size() != N || exp_q.size() != N) begin
      bad++; $display("FAIL mid_count got=%0d want=%0d", got_q.size(), N);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      total++;
      if ({got_q[i].re, got_q[i].im, got_q[i].last} !== {exp_q[i].re, exp_q[i].im, exp_q[i].last}) begin
        bad++;
        $display("FAIL mid_x%0d got=%h/%h/%b want=%h/%h/%b", i, got_q[i].re, got_q[i].im,
                 got_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].last);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_push   = 1'b0;
    bus.in_real   = '0;
    bus.in_imag   = '0;
    bus.out_stall = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_illegal_push();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
